// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: merges the core's instruction and data SRAM-like ports
// into one SRAM-like master port. Address phases are arbitrated
// combinationally. The owner of every accepted transaction is recorded in an
// in-order ID FIFO so that each data_ok/rdata return reaches the right master.
//
// Optional build macro:
//   ARB_RR_EN - round-robin arbitration on contention instead of the default
//               fixed data-over-inst priority.

module cpu_bus_arbiter #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_cache,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_cache,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        proto_err
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    // ID encoding stored in the FIFO: 0 = instruction, 1 = data.
    logic [DEPTH-1:0] id_fifo;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W:0]   count;

    logic full;
    logic gnt_i;
    logic gnt_d;
    logic push;
    logic pop;
    logic pop_id;
    logic stray_ok;

`ifdef ARB_RR_EN
    logic rr_last;

    // Grant: on contention favour the master that was not granted last time.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (!full) begin
            gnt_d = data_req && (!inst_req || !rr_last);
            gnt_i = inst_req && (!data_req || rr_last);
        end
    end

    // Remember the owner of the most recently accepted transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (push) begin
            rr_last <= gnt_d;
        end
    end
`else
    // Grant: fixed priority, data beats instruction; nothing granted when full.
    always_comb begin
        gnt_d = data_req && !full;
        gnt_i = inst_req && !data_req && !full;
    end
`endif

    // Handshake decode and master-port field steering.
    always_comb begin
        full     = (count == FULL_CNT);
        m_req    = gnt_i || gnt_d;
        push     = m_req && m_addr_ok;
        pop      = m_data_ok && (count != '0);
        stray_ok = m_data_ok && (count == '0);
        pop_id   = id_fifo[rd_ptr];

        inst_addr_ok = gnt_i && m_addr_ok;
        data_addr_ok = gnt_d && m_addr_ok;
        inst_data_ok = pop && !pop_id;
        data_data_ok = pop && pop_id;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;

        m_cache = inst_cache;
        m_wr    = 1'b0;
        m_wstrb = 4'h0;
        m_addr  = inst_addr;
        m_size  = 3'd2;
        m_wdata = 32'h0;
        if (gnt_d) begin
            m_cache = data_cache;
            m_wr    = data_wr;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_size  = data_size;
            m_wdata = data_wdata;
        end

        busy = (count != '0);
    end

    // ID FIFO, pointers, occupancy and the sticky stray-return flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_fifo   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= gnt_d;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (stray_ok) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed bench for cpu_bus_arbiter. Expected owner IDs
// are queued when an address handshake is expected and popped when the
// slave side returns data_ok. Honours ARB_RR_EN for the arbitration model.

module tb_cpu_bus_arbiter;

    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_cache, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_cache, m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [31:0] m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy, proto_err;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_id_q[$];
    logic model_proto;
    logic model_rr_last;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    cpu_bus_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .m_req(m_req), .m_cache(m_cache), .m_wr(m_wr), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    // One comparison: counts it and reports a miscompare with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check combinational outputs against the
    // scoreboard model, advance one clock and check the registered status.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic [31:0] da, input logic dw,
                                 input logic aok, input logic dok, input logic [31:0] rd);
        logic full, gi, gd, id;
        inst_req   = ir;
        inst_addr  = ia;
        inst_cache = 1'b0;
        data_req   = dr;
        data_addr  = da;
        data_wr    = dw;
        data_wstrb = dw ? 4'hF : 4'h0;
        data_size  = 3'd1;
        data_wdata = 32'hDEADBEEF;
        data_cache = 1'b1;
        m_addr_ok  = aok;
        m_data_ok  = dok;
        m_rdata    = rd;
        #1;
        full = (exp_id_q.size() == DEPTH);
`ifdef ARB_RR_EN
        gd = !full && dr && (!ir || !model_rr_last);
        gi = !full && ir && (!dr || model_rr_last);
`else
        gd = !full && dr;
        gi = !full && ir && !dr;
`endif
        checkOutput("m_req", m_req, gi || gd);
        checkOutput("m_addr", m_addr, gd ? da : ia);
        checkOutput("m_wr", m_wr, gd && dw);
        checkOutput("m_wstrb", m_wstrb, (gd && dw) ? 4'hF : 4'h0);
        checkOutput("m_size", m_size, gd ? 3'd1 : 3'd2);
        checkOutput("m_wdata", m_wdata, gd ? 32'hDEADBEEF : 32'h0);
        checkOutput("m_cache", m_cache, gd);
        checkOutput("inst_addr_ok", inst_addr_ok, gi && aok);
        checkOutput("data_addr_ok", data_addr_ok, gd && aok);
        if (dok && exp_id_q.size() != 0) begin
            id = exp_id_q.pop_front();
            checkOutput("inst_data_ok", inst_data_ok, !id);
            checkOutput("data_data_ok", data_data_ok, id);
            checkOutput("inst_rdata", inst_rdata, rd);
            checkOutput("data_rdata", data_rdata, rd);
        end else begin
            checkOutput("inst_data_ok_idle", inst_data_ok, 1'b0);
            checkOutput("data_data_ok_idle", data_data_ok, 1'b0);
            if (dok) model_proto = 1'b1;
        end
        if ((gi || gd) && aok) begin
            exp_id_q.push_back(gd);
            model_rr_last = gd;
        end
        @(posedge clk);
        #1;
        checkOutput("busy", busy, exp_id_q.size() != 0);
        checkOutput("proto_err", proto_err, model_proto);
    endtask

    // Asynchronous reset: status must clear before any clock edge.
    task automatic doReset();
        reset = 1'b1;
        #2;
        checkOutput("busy_async_rst", busy, 1'b0);
        checkOutput("proto_err_async_rst", proto_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_id_q.delete();
        model_proto   = 1'b0;
        model_rr_last = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_cache = 0; inst_addr = 0;
        data_req = 0; data_cache = 0; data_wr = 0; data_wstrb = 0;
        data_addr = 0; data_size = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        model_proto = 1'b0;
        model_rr_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_m_req", m_req, 1'b0);
        checkOutput("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        checkOutput("rst_data_addr_ok", data_addr_ok, 1'b0);
        checkOutput("rst_inst_data_ok", inst_data_ok, 1'b0);
        checkOutput("rst_data_data_ok", data_data_ok, 1'b0);
        checkOutput("rst_proto_err", proto_err, 1'b0);
        reset = 1'b0;

        // Instruction-only stream, data_ok two cycles after each accept.
        applyStimulus(1, 32'hBFC00000, 0, 0, 0, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00004, 0, 0, 0, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00008, 0, 0, 0, 1, 1, 32'h11111111);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 1, 32'h22222222);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 1, 32'h33333333);

        // Contention between both masters, then in-order routed returns.
        doReset();
        applyStimulus(1, 32'hBFC00100, 1, 32'h80001000, 1, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00104, 0, 32'h0, 0, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00108, 1, 32'h80001004, 1, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC0010C, 1, 32'h80001008, 0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hA0000000 + i);

        // Fill to DEPTH without returns; full blocks, one return frees one slot.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 32'hBFC00200 + 4 * i, 0, 32'h0, 0, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00210, 1, 32'h80002000, 1, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00210, 1, 32'h80002000, 1, 1, 1, 32'h5A5A5A5A);
        applyStimulus(1, 32'hBFC00210, 1, 32'h80002000, 1, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00214, 1, 32'h80002004, 1, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hB0000000 + i);

        // Steady push+pop at occupancy 2 across 20 transactions (pointer wrap).
        doReset();
        for (int i = 0; i < 20; i++)
            applyStimulus((i % 3) != 1, 32'hBFC00300 + 4 * i,
                          (i % 3) != 0, 32'h80003000 + 4 * i, (i % 2) == 0,
                          1, exp_id_q.size() >= 2, $urandom);
        for (int i = 0; i < DEPTH && exp_id_q.size() != 0; i++)
            applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, $urandom);

        // Stray data_ok with nothing in flight sets a sticky error.
        doReset();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'hCAFEF00D);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
        doReset();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);

        // Asynchronous reset with three transactions in flight.
        applyStimulus(1, 32'hBFC00400, 0, 32'h0, 0, 1, 0, 32'h0);
        applyStimulus(0, 32'h0, 1, 32'h80004000, 0, 1, 0, 32'h0);
        applyStimulus(1, 32'hBFC00404, 0, 32'h0, 0, 1, 0, 32'h0);
        doReset();
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0);
        doReset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Merges the core's instruction and data SRAM-like request ports into one SRAM-like master port toward the cache/AXI bridge.
- Each master's port uses the req/addr_ok/data_ok handshake.
- Arbitrates the address phase and records the requester of every accepted transaction in an in-order ID FIFO.
- Routes each returning data_ok/rdata to the master that issued the transaction.

Parameters:
- DEPTH, 4: maximum in-flight (accepted, not yet returned) transactions; power of 2, ≥2.
- IDX_W, 2: FIFO pointer width; 2^IDX_W must equal DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction request.
- inst_cache  in  1  cacheable attribute.
- inst_addr  in  32  physical fetch address.
- inst_addr_ok  out  1  instruction address accepted.
- inst_data_ok  out  1  instruction data returned.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data request.
- data_cache  in  1  cacheable attribute.
- data_wr  in  1  1 = write.
- data_wstrb  in  4  byte strobes.
- data_addr  in  32  physical data address.
- data_size  in  3  access size.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  data read return or write ack.
- data_rdata  out  32  data read data.
- m_req  out  1  merged request.
- m_cache  out  1  merged cacheable attribute.
- m_wr  out  1  merged write flag.
- m_wstrb  out  4  merged byte strobes.
- m_addr  out  32  merged address.
- m_size  out  3  merged access size.
- m_wdata  out  32  merged write data.
- m_addr_ok  in  1  slave accepted address.
- m_data_ok  in  1  slave returned data/ack.
- m_rdata  in  32  slave read data.
- busy  out  1  at least one transaction in flight.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- State:
  - FIFO of 1-bit IDs (0 = inst, 1 = data) with wr_ptr, rd_ptr (IDX_W bits, wrap modulo DEPTH).
  - count, IDX_W+1 bits.
  - proto_err.
  - rr_last (only when the optional feature is compiled in).
- Reset (asynchronous): pointers and count = 0, proto_err = 0, rr_last = 1.
- Outputs after reset: m_req = 0 unless inputs request, busy = 0, all addr_ok/data_ok = 0.
- full = (count == DEPTH). When full, m_req = 0 and neither master receives addr_ok.
- Grant (combinational, zero latency):
  - Fixed priority: gnt_d = data_req && !full; gnt_i = inst_req && !data_req && !full.
  - m_req = gnt_i || gnt_d.
- m_* fields come from the granted master.
  - For an inst grant: m_wr = 0, m_wstrb = 0, m_size = 3'd2, m_wdata = 0.
  - With no grant, fields follow the inst port.
- Address handshakes: inst_addr_ok = gnt_i && m_addr_ok; data_addr_ok = gnt_d && m_addr_ok.
- Grant may change between cycles while a request is pending and unaccepted. No transaction is committed until addr_ok.
- Push: when m_req && m_addr_ok, write the granted ID at wr_ptr and increment wr_ptr.
- Pop: when m_data_ok && count != 0, read the ID at rd_ptr and increment rd_ptr.
  - inst_data_ok = pop && ID == 0.
  - data_data_ok = pop && ID == 1.
  - m_rdata is broadcast to both inst_rdata and data_rdata.
- count: push only → +1; pop only → −1; push and pop together → unchanged, with both pointers advancing.
  - Push at full cannot occur because m_req is gated by full.
  - Pop at count == 1 with a simultaneous push leaves count = 1.
- Returns are strictly in acceptance order. A data_ok in the same cycle as its own addr_ok is unsupported; a same-cycle pop always refers to an older entry.
- m_data_ok while count == 0:
  - Ignored: no master data_ok, pointers unchanged.
  - proto_err set to 1 and held until reset.
- busy = (count != 0), registered-state derived.
- Reset mid-operation drops all in-flight IDs. Later stray m_data_ok raises proto_err.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin on contention: when both req are high, grant the master not equal to rr_last.
  - rr_last updates to the granted ID on every push.
  - A single requester is always granted when not full.
- Undefined: fixed data-over-inst priority as above; rr_last is absent.

Test Plan:
- Inst-only stream, slave addr_ok=1 every cycle, data_ok 2 cycles later, addrs 0xBFC00000/04/08 → m_addr matches in order, inst_data_ok three times with m_rdata echoed, busy falls after the last return.
- inst_req and data_req high together, data_addr 0x80001000 wr=1 wstrb=4'hF wdata=0xDEADBEEF:
  - Fixed priority: data accepted first, inst accepted next cycle, returns routed data then inst.
  - With ARB_RR_EN: inst first after reset, then alternation.
- Slave withholds data_ok with DEPTH=4 → after 4 accepts m_req=0 and both addr_ok=0. One data_ok returns to the first ID; the next cycle allows exactly one accept.
- Push and pop in the same cycle at count=2 → count stays 2, both pointers advance; run 20 transactions to exercise pointer wrap with correct routing.
- m_data_ok pulse at count=0 → no master data_ok, proto_err=1 stays 1; assert reset → proto_err=0, busy=0.
- Assert reset asynchronously with 3 transactions in flight → busy=0 immediately (no clock edge needed), FIFO empty.
